// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache with whole-line refill over a single-outstanding bus.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module l1_icache #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  input  logic        resp_ready,
  input  logic        kill,
  input  logic        inval,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_done,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OB    = $clog2(WORDS_PER_LINE);
  localparam int IB    = $clog2(LINES);
  localparam int AW    = OB + IB;
  localparam int TAG_W = 32 - 2 - OB - IB;
  localparam int CW    = (OB > 0) ? OB : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_HOLD} state_t;

  state_t            r_state;
  logic [31:0]       r_addr;
  logic [31:0]       r_word;
  logic [31:0]       r_bus_addr;
  logic              r_bus_ren;
  logic              r_drop;
  logic              r_noval;
  logic [LINES-1:0]  r_valid;
  logic [31:0]       r_rdata;
  logic [TAG_W-1:0]  r_rtag;
  logic [31:0]       r_data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]  r_tag_mem  [LINES];

  logic [IB-1:0]     w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_off_match;
  logic              w_last;
  logic              w_fill_done;
  logic              w_unused;

  assign w_idx       = r_addr[2+OB +: IB];
  assign w_tag       = r_addr[31 -: TAG_W];
  assign w_hit       = r_valid[w_idx] && (r_rtag == w_tag);
  // The word-offset bits of the bus address double as the refill word counter.
  assign w_off_match = (OB == 0) || (r_bus_addr[2 +: CW] == r_addr[2 +: CW]);
  assign w_last      = (OB == 0) || (r_bus_addr[2 +: CW] == CW'(WORDS_PER_LINE - 1));
  assign w_fill_done = (r_state == S_REFILL) && bus_done && w_last;
  assign w_unused    = ^req_addr[1:0];

  always_comb begin
    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE:   w_req_ready = 1'b1;
      S_LOOKUP: w_req_ready = kill || (w_hit && resp_ready);
      S_HOLD:   w_req_ready = kill || resp_ready;
      default:  w_req_ready = 1'b0;
    endcase
  end

  assign w_accept   = req_valid && w_req_ready;
  assign req_ready  = w_req_ready;
  assign resp_valid = !kill && (((r_state == S_LOOKUP) && w_hit) || (r_state == S_HOLD));
  assign resp_instr = (r_state == S_LOOKUP) ? r_rdata : r_word;
  assign resp_addr  = r_addr;
  assign bus_ren    = r_bus_ren;
  assign bus_addr   = r_bus_addr;

  // Data and tag arrays: synchronous read on accept, written only during refill.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rdata <= r_data_mem[req_addr[2 +: AW]];
      r_rtag  <= r_tag_mem[req_addr[2+OB +: IB]];
    end
    if ((r_state == S_REFILL) && bus_done)
      r_data_mem[r_bus_addr[2 +: AW]] <= bus_rdata;
    if (w_fill_done)
      r_tag_mem[w_idx] <= w_tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_valid <= '0;
    else if (inval)
      r_valid <= '0;
    else if (w_fill_done && !r_noval)
      r_valid[w_idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_word     <= '0;
      r_bus_addr <= '0;
      r_bus_ren  <= 1'b0;
      r_drop     <= 1'b0;
      r_noval    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= {req_addr[31:2], 2'b00};
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_req_ready) begin
            if (w_accept) r_addr <= {req_addr[31:2], 2'b00};
            r_state <= w_accept ? S_LOOKUP : S_IDLE;
          end else if (w_hit) begin
            r_word  <= r_rdata;
            r_state <= S_HOLD;
          end else begin
            r_bus_addr <= {r_addr[31:2+OB], {(2+OB){1'b0}}};
            r_bus_ren  <= 1'b1;
            r_drop     <= 1'b0;
            r_noval    <= inval;
            r_state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (kill)  r_drop  <= 1'b1;
          if (inval) r_noval <= 1'b1;
          if (bus_done) begin
            if (w_off_match) r_word <= bus_rdata;
            if (w_last) begin
              r_bus_ren <= 1'b0;
              r_state   <= (r_drop || kill) ? S_IDLE : S_HOLD;
            end else begin
              r_bus_addr <= r_bus_addr + 32'd4;
            end
          end
        end
        S_HOLD: begin
          if (w_req_ready) begin
            if (w_accept) r_addr <= {req_addr[31:2], 2'b00};
            r_state <= w_accept ? S_LOOKUP : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Scoreboard bench for l1_icache: driver pushes expectations from a line-level cache model,
// a monitor pops them on every delivered response, and a bus responder serves refills.
module tb_l1_icache;
  localparam int LINES  = 64;
  localparam int WPL    = 4;
  localparam int LINE_B = WPL * 4;
  localparam int SPAN_B = LINES * LINE_B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_ready = 1'b0;
  logic        kill = 1'b0;
  logic        inval = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic [31:0] bus_rdata = '0;
  logic        bus_done = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  l1_icache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_addr(resp_addr),
    .resp_ready(resp_ready), .kill(kill), .inval(inval),
    .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_done(bus_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    int          acc_cyc;
    int          done_snap;
    bit          seen;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          m_v[LINES];
  int unsigned m_tag[LINES];
  bit          pend_v = 0;
  int unsigned pend_idx, pend_tag;
  int          last_acc = -10;
  int          m_hits = 0;
  int          m_misses = 0;
  logic [31:0] bus_base = '0;
  int          bus_k = 0;
  int          done_total = 0;
  bit          bus_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a / 4) * 4;
    return w * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (m_v[i]) m_v[i] = 0;
    pend_v   = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One clock of stimulus; the model is updated from what the bench itself drove.
  task automatic cyc_drive(input logic rv, input logic [31:0] a, input logic rr,
                           input logic k, input logic iv, output bit acc);
    int unsigned idx, tg;
    exp_t e;
    @(posedge clk); #1;
    req_valid = rv; req_addr = a; resp_ready = rr; kill = k; inval = iv;
    @(negedge clk);
    acc = rv && req_ready;
    if (k) begin
      q.delete();
      if (last_acc == cyc - 1) pend_v = 0;
    end
    if (iv) begin
      foreach (m_v[i]) m_v[i] = 0;
      pend_v = 0;
    end
    if (acc) begin
      if (pend_v) begin
        m_v[pend_idx]   = 1;
        m_tag[pend_idx] = pend_tag;
        pend_v = 0;
      end
      idx = (a / LINE_B) % LINES;
      tg  = a / SPAN_B;
      e.addr = (a / 4) * 4;
      e.data = mem_word(a);
      e.hit  = m_v[idx] && (m_tag[idx] == tg);
      e.acc_cyc   = cyc;
      e.done_snap = done_total;
      e.seen      = 0;
      q.push_back(e);
      if (e.hit) m_hits++;
      else begin
        m_misses++;
        pend_v = 1; pend_idx = idx; pend_tag = tg;
        bus_base = (a / LINE_B) * LINE_B;
        bus_k = 0;
      end
      last_acc = cyc;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while ((q.size() != 0 || bus_ren) && n < 300) begin
      cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Bus responder: serves each strobe after a fixed or random number of wait cycles.
  initial begin
    int wcnt = 0;
    int wlim = 2;
    forever begin
      @(posedge clk); #1;
      bus_done = 1'b0;
      if (bus_ren === 1'b1) begin
        if (wcnt < wlim) wcnt++;
        else begin
          chk("bus_addr", bus_addr, bus_base + 32'(4 * bus_k));
          bus_rdata = mem_word(bus_addr);
          bus_done  = 1'b1;
          done_total++;
          bus_k++;
          wcnt = 0;
          wlim = bus_rand ? int'($urandom_range(0, 2)) : 2;
        end
      end else wcnt = 0;
    end
  end

  // Monitor: compares every presented response against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (resp_valid === 1'b1) begin
          if (q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
          else begin
            if (!q[0].seen) begin
              q[0].seen = 1;
              if (q[0].hit) begin
                chk("hit_latency", 32'(cyc - q[0].acc_cyc), 32'd1);
                chk("hit_bus_reads", 32'(done_total - q[0].done_snap), 32'd0);
              end else begin
                chk("miss_bus_reads", 32'(done_total - q[0].done_snap), 32'(WPL));
              end
            end
            chk("resp_addr", resp_addr, q[0].addr);
            chk("resp_instr", resp_instr, q[0].data);
            if (resp_ready !== 1'b1) chk("stall_req_ready", 32'(req_ready), 32'd0);
            else void'(q.pop_front());
          end
        end
        if (q.size() == 0 && bus_ren !== 1'b1) chk("free_req_ready", 32'(req_ready), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] a;
    bit rv, rr, k, iv;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_bus_ren", 32'(bus_ren), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_resp_instr", resp_instr, 32'd0);
    chk("rst_resp_addr", resp_addr, 32'd0);
    @(posedge clk); #2; rst = 1'b1;

    // Cold miss, then hit streaming on the filled line.
    cyc_drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, acc);
    drain();
    cyc_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, acc);
    cyc_drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, acc);
    chk("stream_accept", 32'(acc), 32'd1);
    cyc_drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, acc);
    cyc_drive(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Conflict eviction on the same index.
    cyc_drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, acc);
    drain();
    cyc_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Backpressure: three stalled cycles, released on the fourth.
    cyc_drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    drain();

    // Kill during refill, then the filled line hits.
    cyc_drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, acc);
    idle(4);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
    drain();
    cyc_drive(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Kill with a new request while holding a response.
    cyc_drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, acc);
    cyc_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    cyc_drive(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, acc);
    chk("kill_hold_accept", 32'(acc), 32'd1);
    drain();

    // Invalidate forces a refill of a previously filled line.
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
    cyc_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Asynchronous reset in the middle of a refill.
    cyc_drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, acc);
    idle(3);
    @(posedge clk); #3;
    rst = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("midrst_bus_ren", 32'(bus_ren), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    cyc_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Randomized traffic over a few conflicting tags and lines.
    bus_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      a  = 32'($urandom_range(0, 2)) * 32'(SPAN_B) + 32'($urandom_range(0, 7)) * 32'(LINE_B)
         + 32'($urandom_range(0, 15));
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 3) != 0);
      k  = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 49) == 0);
      cyc_drive(rv, a, rr, k, iv, acc);
    end
    drain();

`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'(m_hits));
    chk("miss_count", miss_count, 32'(m_misses));
`else
    chk("hit_count_tied", hit_count, 32'd0);
    chk("miss_count_tied", miss_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_icache.md
Name: l1_icache

Overview:
- Parametrised direct-mapped L1 instruction cache. Replaces the fixed, preloaded instruction BRAM in front of the pipelined core's fetch stage.
- Serves the fetch stage through a valid/ready request/response pair.
- Refills whole lines over the shared data bus on a miss.
- Supports whole-cache invalidate and a kill input that discards in-flight fetches on PC redirect.

Parameters:
LINES, 64, number of cache lines; power of 2, minimum 2
WORDS_PER_LINE, 4, 32-bit words per line; power of 2, minimum 1
TAG_W, 32-2-$clog2(WORDS_PER_LINE)-$clog2(LINES), tag width (derived, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  fetch request present
req_addr  in  32  fetch byte address; bits [1:0] ignored
req_ready  out  1  request accepted when req_valid && req_ready
resp_valid  out  1  instruction available
resp_instr  out  32  instruction word
resp_addr  out  32  word-aligned address of resp_instr
resp_ready  in  1  consumer takes response when resp_valid && resp_ready
kill  in  1  discard the current or pending response (redirect)
inval  in  1  invalidate all lines
bus_addr  out  32  refill word address (byte address, word-aligned)
bus_ren  out  1  refill read strobe
bus_rdata  in  32  refill data; valid in the cycle bus_done=1
bus_done  in  1  bus read complete
hit_count  out  32  hit counter (see Optional Feature)
miss_count  out  32  miss counter (see Optional Feature)

Behaviour:
- Storage:
  - Data array: LINES*WORDS_PER_LINE words, synchronous read, BRAM-inferable.
  - Tag array: LINES entries, synchronous read.
  - Valid bits: LINES flops.
- Address split: [1:0] byte; then word-offset; then index; then tag (MSBs).
- Reset (rst low, async):
  - State IDLE; all valid bits clear.
  - req_ready=1; resp_valid=0; bus_ren=0; bus_addr=0; resp_instr=0; resp_addr=0; drop flag clear.
- FSM states: IDLE, LOOKUP, REFILL, HOLD.
- IDLE:
  - req_ready=1.
  - On accept, latch address, issue array reads, then go to LOOKUP.
- LOOKUP:
  - hit = valid[idx] && tag match.
  - Hit: resp_valid=1 combinationally from the array outputs; one-cycle latency from accept to response.
    - resp_ready=1: req_ready=1; a new accept goes back to LOOKUP, otherwise to IDLE. Sustained throughput is one fetch per cycle on hits.
    - resp_ready=0: capture the word and go to HOLD; req_ready=0.
  - Miss: resp_valid=0, req_ready=0; go to REFILL with word counter 0.
- REFILL:
  - Read words 0..WORDS_PER_LINE-1 of the line-aligned base, in order.
  - bus_ren=1 and bus_addr stay stable until bus_done=1.
  - On bus_done, write bus_rdata to the data array and capture it if its offset equals the requested offset. Advance the counter; the next word is issued the following cycle, so bus_ren may stay high.
  - After the last word: write the tag, set the valid bit, drop bus_ren to 0, then go to HOLD (or IDLE if the drop flag is set).
- HOLD:
  - resp_valid=1; response stays stable.
  - On resp_ready: req_ready=1; a new accept goes to LOOKUP, otherwise to IDLE.
- kill:
  - In LOOKUP or HOLD: resp_valid is forced to 0 that cycle and the response is discarded. req_ready=1; a simultaneous req_valid is accepted and goes to LOOKUP, otherwise the state goes to IDLE.
  - In REFILL: set the drop flag. The refill runs to completion and the line is filled, with no response. req_ready=0 until REFILL exits.
  - In IDLE: no effect; a simultaneous request is accepted.
- inval:
  - Clears all valid bits at the next edge.
  - During REFILL, the finishing line's valid bit is not set. The pending response is still delivered unless killed.
  - inval coincident with a LOOKUP hit: that hit is still returned; later lookups miss.
- Bus: only one outstanding read. bus_ren never asserts outside REFILL.
- Self-modifying code is not supported; software issues inval after writing instruction memory.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments once per LOOKUP hit, including killed ones.
  - miss_count increments once per LOOKUP miss.
  - Both are 32-bit and wrap 0xFFFFFFFF→0; both reset to 0.
- Undefined: both ports are tied to 0 and the counter logic is absent.

Test Plan:
- Cold miss: after reset, request 0x00000104 (LINES=64, WPL=4).
  - bus reads 0x100, 0x104, 0x108, 0x10C, each with bus_done after 2 cycles.
  - resp_addr=0x104 with the word from 0x104; resp_valid stays 0 until the fourth bus_done.
- Hit streaming: after the fill, requests 0x100, 0x104, 0x108, 0x10C back-to-back with resp_ready=1 → four responses on consecutive cycles, bus_ren=0 throughout.
- Conflict eviction: fill 0x100, then request 0x500 (same index, tag differs) → refill from 0x500; a subsequent request for 0x100 misses again.
- Backpressure: hit with resp_ready=0 for 3 cycles → resp_valid and resp_instr held, req_ready=0; released on the 4th cycle.
- Kill during refill: kill=1 in the second refill word → no response; a following request for the same address hits with 1-cycle latency. Kill together with req_valid in HOLD → new request accepted the same cycle.
- Invalidate and reset: inval=1 after filling 0x100 → next 0x100 request refills. rst low mid-REFILL → bus_ren=0 immediately; next 0x100 request misses.
